herald_result_ser: RTL and testbench

HERALD_RESULT_SER -- requirements
Module: herald_result_ser

---
 rtl/herald_pkg.sv | 16 +
 rtl/herald_sync2.sv | 24 ++
 rtl/herald_result_ser.sv | 108 ++++++++++
 tb/tb_herald_result_ser.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/herald_pkg.sv
// Shared types and constants for the herald result serializer.
// State encoding, synchronizer depth and byte-index width.
package herald_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;
  localparam int IDX_W       = 4;
  // One extra bit so the counter can reach NBYTES=16.
  localparam int CNT_W       = IDX_W + 1;

endpackage

// File: rtl/herald_sync2.sv
// 1-bit two-flop synchronizer, synchronous active-high reset.
// Ports: clk, rst, d (async input), q (synchronized output).
module herald_sync2
  import herald_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/herald_result_ser.sv
// Streams an NBYTES result word to a host, LSB first, over a
// four-phase valid/ack handshake with an asynchronous ack pin.
// Ports: clk, rst (sync, active-high); load_data/EN_load/RDY_load
// load method; EN_flush abort; ack_in host ack (async);
// byte_out/byte_valid/byte_idx current byte; busy; frames_sent.
module herald_result_ser
  import herald_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*NBYTES-1:0] load_data,
  input  logic               EN_load,
  output logic               RDY_load,
  input  logic               EN_flush,
  input  logic               ack_in,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  output logic [IDX_W-1:0]   byte_idx,
  output logic               busy,
  output logic [7:0]         frames_sent
);

  state_t              state, state_n;
  logic [8*NBYTES-1:0] shift_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          frames_q;
  logic                ack_s;
  logic                load_go;
  logic                adv;
  logic                done;

  herald_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_in),
    .q   (ack_s)
  );

  always_comb begin
    state_n = state;
    load_go = 1'b0;
    adv     = 1'b0;
    done    = 1'b0;
    if (EN_flush) begin
      state_n = IDLE;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (EN_load) begin
            load_go = 1'b1;
            state_n = PRESENT;
          end
        end
        (state == PRESENT): begin
          // A level, not an edge: a stuck-high ack advances at once.
          if (ack_s) begin
            adv     = 1'b1;
            state_n = WAIT_LOW;
          end
        end
        (state == WAIT_LOW): begin
          if (!ack_s) begin
            if (cnt_q < CNT_W'(NBYTES)) begin
              state_n = PRESENT;
            end else begin
              state_n = IDLE;
              done    = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      frames_q <= '0;
    end else begin
      state <= state_n;
      if (EN_flush) begin
        cnt_q <= '0;
      end else if (load_go) begin
        shift_q <= load_data;
        cnt_q   <= '0;
      end else if (adv) begin
        shift_q <= shift_q >> 8;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (done) begin
        frames_q <= frames_q + 8'd1;
      end
    end
  end

  assign RDY_load    = (state == IDLE);
  assign byte_valid  = (state == PRESENT);
  assign busy        = (state != IDLE);
  assign byte_out    = shift_q[7:0];
  assign byte_idx    = cnt_q[IDX_W-1:0];
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_herald_result_ser.sv
// Directed bench for herald_result_ser (NBYTES=4).
// A host model drives the four-phase ack handshake.
module tb_herald_result_ser;

  logic        clk;
  logic        rst;
  logic [31:0] load_data;
  logic        EN_load;
  logic        RDY_load;
  logic        EN_flush;
  logic        ack_in;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [3:0]  byte_idx;
  logic        busy;
  logic [7:0]  frames_sent;

  int n_chk  = 0;
  int n_pass = 0;
  int f_exp  = 0;

  herald_result_ser #(.NBYTES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_data   (load_data),
    .EN_load     (EN_load),
    .RDY_load    (RDY_load),
    .EN_flush    (EN_flush),
    .ack_in      (ack_in),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_idx    (byte_idx),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [31:0] d);
    @(posedge clk);
    #2;
    load_data = d;
    EN_load   = 1'b1;
    @(posedge clk);
    #2;
    EN_load   = 1'b0;
  endtask

  task automatic hs_byte(input logic [7:0] eb,
                         input logic [3:0] ei);
    int k;
    bit st;
    k = 0;
    while (!byte_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_chk++;
    if (byte_valid !== 1'b1)
      $display("FAIL hs_valid: got %b want 1", byte_valid);
    else n_pass++;
    n_chk++;
    if (byte_out !== eb)
      $display("FAIL hs_byte: got %h want %h", byte_out, eb);
    else n_pass++;
    n_chk++;
    if (byte_idx !== ei)
      $display("FAIL hs_idx: got %0d want %0d", byte_idx, ei);
    else n_pass++;
    #1;
    ack_in = 1'b1;
    k = 0;
    st = 1'b1;
    while (byte_valid && k < 40) begin
      @(posedge clk);
      #1;
      if (byte_valid && (byte_out !== eb || byte_idx !== ei))
        st = 1'b0;
      k++;
    end
    n_chk++;
    if (byte_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL hs_drop: valid %b busy %b want 0 1",
               byte_valid, busy);
    else n_pass++;
    n_chk++;
    if (!st)
      $display("FAIL hs_stable: got 0 want 1");
    else n_pass++;
    ack_in = 1'b0;
  endtask

  task automatic end_frame(input string nm);
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    f_exp++;
    n_chk++;
    if (busy !== 1'b0 || RDY_load !== 1'b1)
      $display("FAIL %s_idle: busy %b rdy %b want 0 1",
               nm, busy, RDY_load);
    else n_pass++;
    n_chk++;
    if (frames_sent !== 8'(f_exp))
      $display("FAIL %s_frames: got %0d want %0d",
               nm, frames_sent, 8'(f_exp));
    else n_pass++;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    f_exp = 0;
    n_chk++;
    if (RDY_load !== 1'b1 || byte_valid !== 1'b0 ||
        busy !== 1'b0)
      $display("FAIL rst_ctl: rdy %b val %b busy %b want 1 0 0",
               RDY_load, byte_valid, busy);
    else n_pass++;
    n_chk++;
    if (byte_out !== 8'h00 || byte_idx !== 4'd0)
      $display("FAIL rst_data: byte %h idx %0d want 00 0",
               byte_out, byte_idx);
    else n_pass++;
    n_chk++;
    if (frames_sent !== 8'd0)
      $display("FAIL rst_frames: got %0d want 0", frames_sent);
    else n_pass++;
  endtask

  task automatic test_basic;
    do_load(32'hA1B2C3D4);
    hs_byte(8'hD4, 4'd0);
    hs_byte(8'hC3, 4'd1);
    hs_byte(8'hB2, 4'd2);
    hs_byte(8'hA1, 4'd3);
    end_frame("basic");
  endtask

  task automatic test_latency;
    int n;
    do_load(32'h11223344);
    @(posedge clk);
    #2;
    ack_in = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (byte_valid && n < 10);
    n_chk++;
    if (n != 3)
      $display("FAIL lat_rise: got %0d want 3", n);
    else n_pass++;
    #1;
    ack_in = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!byte_valid && n < 10);
    n_chk++;
    if (n != 3)
      $display("FAIL lat_fall: got %0d want 3", n);
    else n_pass++;
    hs_byte(8'h33, 4'd1);
    hs_byte(8'h22, 4'd2);
    hs_byte(8'h11, 4'd3);
    end_frame("lat");
  endtask

  task automatic test_flush;
    do_load(32'hCAFEBABE);
    hs_byte(8'hBE, 4'd0);
    @(posedge clk);
    #2;
    EN_flush = 1'b1;
    @(posedge clk);
    #2;
    EN_flush = 1'b0;
    n_chk++;
    if (RDY_load !== 1'b1 || busy !== 1'b0 ||
        byte_valid !== 1'b0)
      $display("FAIL flush_idle: rdy %b busy %b val %b want 1 0 0",
               RDY_load, busy, byte_valid);
    else n_pass++;
    n_chk++;
    if (frames_sent !== 8'(f_exp))
      $display("FAIL flush_frames: got %0d want %0d",
               frames_sent, 8'(f_exp));
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (byte_valid !== 1'b0)
      $display("FAIL flush_quiet: got %b want 0", byte_valid);
    else n_pass++;
    do_load(32'h00000055);
    hs_byte(8'h55, 4'd0);
    hs_byte(8'h00, 4'd1);
    hs_byte(8'h00, 4'd2);
    hs_byte(8'h00, 4'd3);
    end_frame("flush");
  endtask

  task automatic test_collision;
    @(posedge clk);
    #2;
    load_data = 32'hFFFFFFFF;
    EN_load   = 1'b1;
    EN_flush  = 1'b1;
    @(posedge clk);
    #2;
    EN_load   = 1'b0;
    EN_flush  = 1'b0;
    n_chk++;
    if (byte_valid !== 1'b0 || RDY_load !== 1'b1)
      $display("FAIL coll_idle: val %b rdy %b want 0 1",
               byte_valid, RDY_load);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (byte_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL coll_quiet: val %b busy %b want 0 0",
               byte_valid, busy);
    else n_pass++;
    do_load(32'h0A0B0C0D);
    load_data = 32'hDEADBEEF;
    EN_load   = 1'b1;
    @(posedge clk);
    #2;
    EN_load   = 1'b0;
    hs_byte(8'h0D, 4'd0);
    EN_load   = 1'b1;
    @(posedge clk);
    #2;
    EN_load   = 1'b0;
    hs_byte(8'h0C, 4'd1);
    hs_byte(8'h0B, 4'd2);
    hs_byte(8'h0A, 4'd3);
    end_frame("coll");
  endtask

  task automatic test_stuck;
    ack_in = 1'b1;
    repeat (4) @(posedge clk);
    do_load(32'h77665544);
    n_chk++;
    if (byte_valid !== 1'b1 || byte_out !== 8'h44)
      $display("FAIL stuck_pres: val %b byte %h want 1 44",
               byte_valid, byte_out);
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if (byte_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL stuck_adv: val %b busy %b want 0 1",
               byte_valid, busy);
    else n_pass++;
    ack_in = 1'b0;
    hs_byte(8'h55, 4'd1);
    hs_byte(8'h66, 4'd2);
    hs_byte(8'h77, 4'd3);
    end_frame("stuck");
  endtask

  task automatic test_wrap;
    test_reset();
    for (int i = 0; i < 255; i++) begin
      do_load(32'h03020100);
      hs_byte(8'h00, 4'd0);
      hs_byte(8'h01, 4'd1);
      hs_byte(8'h02, 4'd2);
      hs_byte(8'h03, 4'd3);
      end_frame("wrapf");
    end
    n_chk++;
    if (frames_sent !== 8'd255)
      $display("FAIL wrap_255: got %0d want 255", frames_sent);
    else n_pass++;
    do_load(32'h03020100);
    hs_byte(8'h00, 4'd0);
    hs_byte(8'h01, 4'd1);
    hs_byte(8'h02, 4'd2);
    hs_byte(8'h03, 4'd3);
    end_frame("wrapl");
    n_chk++;
    if (frames_sent !== 8'd0)
      $display("FAIL wrap_0: got %0d want 0", frames_sent);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    do_load(32'h9ABCDEF0);
    hs_byte(8'hF0, 4'd0);
    hs_byte(8'hDE, 4'd1);
    hs_byte(8'hBC, 4'd2);
    hs_byte(8'h9A, 4'd3);
    end_frame("pre");
    do_load(32'h12345678);
    hs_byte(8'h78, 4'd0);
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (byte_valid !== 1'b1 || byte_out !== 8'h56)
      $display("FAIL mid_pres: val %b byte %h want 1 56",
               byte_valid, byte_out);
    else n_pass++;
    test_reset();
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (byte_valid !== 1'b0 || busy !== 1'b0 ||
        frames_sent !== 8'd0)
      $display("FAIL mid_after: val %b busy %b fr %0d want 0 0 0",
               byte_valid, busy, frames_sent);
    else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    load_data = '0;
    EN_load   = 1'b0;
    EN_flush  = 1'b0;
    ack_in    = 1'b0;
    test_reset();
    test_basic();
    test_latency();
    test_flush();
    test_collision();
    test_stuck();
    test_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
